// File: rtl/tcm_arb_pkg.sv
// Shared types and constants for the data-TCM arbiter.
// Struct widths follow TCM_DW; the arbiter's DATA_WIDTH defaults to the same value.
package tcm_arb_pkg;
    localparam int TCM_AW = 32;
    localparam int TCM_DW = 32;
    localparam int M_LSU  = 0;
    localparam int M_LDR  = 1;

    typedef struct packed {
        logic                  we;
        logic [TCM_AW-1:0]     addr;
        logic [TCM_DW-1:0]     wdata;
        logic [TCM_DW/8-1:0]   wstrb;
    } tcm_req_t;

    typedef struct packed {
        logic [TCM_DW-1:0]     rdata;
        logic                  err;
    } tcm_rsp_t;
endpackage

// File: rtl/tcm_arb_if.sv
// Per-master request/response channel into the TCM arbiter.
interface tcm_arb_if import tcm_arb_pkg::*; #(parameter int DATA_WIDTH = TCM_DW);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [31:0]             req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/tcm_rsp_slot.sv
// Per-master response path: tracks last cycle's grant and parks an unaccepted
// response in a one-entry hold register until the master takes it.
module tcm_rsp_slot import tcm_arb_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              grant,
    input  logic              grant_we,
    input  logic              grant_err,
    input  logic [TCM_DW-1:0] ram_rdata,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output tcm_rsp_t          rsp,
    output logic              eligible
);
    logic     inflight, fl_we, fl_err, hold_vld;
    tcm_rsp_t hold, live;

    always_comb begin
        live.err   = fl_err;
        live.rdata = (fl_we || fl_err) ? '0 : ram_rdata;
    end

    // In-flight and held responses never coexist: a grant needs the slot drained.
    assign rsp_valid = inflight | hold_vld;
    assign rsp       = inflight ? live : (hold_vld ? hold : '0);
    assign eligible  = !rsp_valid || rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            fl_we    <= 1'b0;
            fl_err   <= 1'b0;
            hold_vld <= 1'b0;
            hold     <= '0;
        end else begin
            inflight <= grant;
            fl_we    <= grant_we;
            fl_err   <= grant_err;
            if (inflight && !rsp_ready) begin
                hold_vld <= 1'b1;
                hold     <= live;
            end else if (hold_vld && rsp_ready) begin
                hold_vld <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/tcm_arbiter.sv
// Two-master arbiter in front of the single-port DTCM: fixed priority to the LSU,
// with a starvation override that hands the loader one grant after STARVE_LIMIT losses.
module tcm_arbiter import tcm_arb_pkg::*; #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = TCM_DW,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    tcm_arb_if.slave                m0,
    tcm_arb_if.slave                m1,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-3:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_wstrb,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [1:0] rq_valid, rsp_ready, rsp_valid, elig, cand, gnt, oor;
    tcm_req_t   rq  [2];
    tcm_rsp_t   rsp [2];
    tcm_req_t   sel;
    logic       sel_oor, hit, ovr;
    logic [CW-1:0] starve_cnt, cnt_nxt;

    assign rq_valid[M_LSU]  = m0.req_valid;
    assign rq_valid[M_LDR]  = m1.req_valid;
    assign rq[M_LSU]        = '{m0.req_we, m0.req_addr, m0.req_wdata, m0.req_wstrb};
    assign rq[M_LDR]        = '{m1.req_we, m1.req_addr, m1.req_wdata, m1.req_wstrb};
    assign rsp_ready[M_LSU] = m0.rsp_ready;
    assign rsp_ready[M_LDR] = m1.rsp_ready;

    for (genvar i = 0; i < 2; i++) begin : g_slot
        assign oor[i] = |rq[i].addr[TCM_AW-1:ADDR_WIDTH];
        tcm_rsp_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .grant     (gnt[i]),
            .grant_we  (rq[i].we),
            .grant_err (oor[i]),
            .ram_rdata (ram_rdata),
            .rsp_ready (rsp_ready[i]),
            .rsp_valid (rsp_valid[i]),
            .rsp       (rsp[i]),
            .eligible  (elig[i])
        );
    end

    assign cand       = rq_valid & elig & {2{!rst}};
    assign gnt[M_LDR] = cand[M_LDR] & (ovr | !cand[M_LSU]);
    assign gnt[M_LSU] = cand[M_LSU] & !gnt[M_LDR];

    assign m0.req_ready = gnt[M_LSU];
    assign m1.req_ready = gnt[M_LDR];
    assign m0.rsp_valid = rsp_valid[M_LSU];
    assign m1.rsp_valid = rsp_valid[M_LDR];
    assign m0.rsp_rdata = rsp[M_LSU].rdata;
    assign m1.rsp_rdata = rsp[M_LDR].rdata;
    assign m0.rsp_err   = rsp[M_LSU].err;
    assign m1.rsp_err   = rsp[M_LDR].err;

    // Out-of-window grants still take the slot but never touch the SRAM.
    assign sel       = gnt[M_LDR] ? rq[M_LDR] : rq[M_LSU];
    assign sel_oor   = gnt[M_LDR] ? oor[M_LDR] : oor[M_LSU];
    assign hit       = |gnt && !sel_oor;
    assign ram_en    = hit;
    assign ram_we    = hit && sel.we;
    assign ram_addr  = sel.addr[ADDR_WIDTH-1:2];
    assign ram_wdata = sel.wdata;
    assign ram_wstrb = (hit && sel.we) ? sel.wstrb : '0;

    logic unused_addr;
    assign unused_addr = ^{sel.addr[TCM_AW-1:ADDR_WIDTH], sel.addr[1:0]};

    always_comb begin
        cnt_nxt = starve_cnt;
        if (gnt[M_LDR] || !rq_valid[M_LDR])
            cnt_nxt = '0;
        else if (cand[M_LDR] && starve_cnt != LIM)
            cnt_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            ovr        <= 1'b0;
        end else begin
            starve_cnt <= cnt_nxt;
            if (gnt[M_LDR])
                ovr <= 1'b0;
            else if (cnt_nxt == LIM)
                ovr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tcm_arbiter.sv
// Directed bench for tcm_arbiter with a behavioural byte-strobed SRAM (1-cycle read).
module tb_tcm_arbiter;
    import tcm_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en, ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] mem [0:16383];
    int total = 0;
    int bad   = 0;

    tcm_arb_if #(.DATA_WIDTH(32)) m0_if ();
    tcm_arb_if #(.DATA_WIDTH(32)) m1_if ();

    tcm_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic drv0(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        m0_if.req_valid = v; m0_if.req_we = we; m0_if.req_addr = a;
        m0_if.req_wdata = d; m0_if.req_wstrb = s;
    endtask

    task automatic drv1(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        m1_if.req_valid = v; m1_if.req_we = we; m1_if.req_addr = a;
        m1_if.req_wdata = d; m1_if.req_wstrb = s;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drv0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        drv1(1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
        m0_if.rsp_ready = 1'b1; m1_if.rsp_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        total++; if (m0_if.req_ready !== 1'b0) begin bad++; $display("FAIL rst_m0_ready got=%0b exp=0", m0_if.req_ready); end
        total++; if (m1_if.req_ready !== 1'b0) begin bad++; $display("FAIL rst_m1_ready got=%0b exp=0", m1_if.req_ready); end
        total++; if ({ram_en, ram_we} !== 2'b00) begin bad++; $display("FAIL rst_ram_en_we got=%b exp=00", {ram_en, ram_we}); end
        total++; if ({m0_if.rsp_valid, m1_if.rsp_valid} !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=00", {m0_if.rsp_valid, m1_if.rsp_valid}); end
        total++; if ({m0_if.rsp_err, m1_if.rsp_err} !== 2'b00) begin bad++; $display("FAIL rst_rsp_err got=%b exp=00", {m0_if.rsp_err, m1_if.rsp_err}); end
        total++; if (m0_if.rsp_rdata !== 32'h0 || m1_if.rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0", m0_if.rsp_rdata, m1_if.rsp_rdata); end
        total++; if (dut.starve_cnt !== '0 || dut.ovr !== 1'b0) begin bad++; $display("FAIL rst_starve got=%0d/%0b exp=0/0", dut.starve_cnt, dut.ovr); end
        @(negedge clk);
        rst = 1'b0;
        drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_single;
        @(negedge clk);
        drv0(1'b1, 1'b1, 32'h200, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        drv0(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF); #1;
        total++; if (m0_if.req_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1) begin bad++; $display("FAIL wr_issue got=rdy%0b en%0b we%0b exp=111", m0_if.req_ready, ram_en, ram_we); end
        total++; if (ram_addr !== 14'h40) begin bad++; $display("FAIL wr_addr got=%h exp=40", ram_addr); end
        total++; if (ram_wdata !== 32'hDEADBEEF || ram_wstrb !== 4'hF) begin bad++; $display("FAIL wr_data got=%h/%h exp=deadbeef/f", ram_wdata, ram_wstrb); end
        @(negedge clk);
        drv0(1'b1, 1'b0, 32'h100, 32'h0, 4'hF); #1;
        total++; if (m0_if.rsp_valid !== 1'b1 || m0_if.rsp_err !== 1'b0 || m0_if.rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp got=v%0b e%0b d%h exp=v1 e0 d0", m0_if.rsp_valid, m0_if.rsp_err, m0_if.rsp_rdata); end
        total++; if (m0_if.req_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_wstrb !== 4'h0) begin bad++; $display("FAIL rd_issue got=rdy%0b en%0b we%0b s%h exp=1 1 0 0", m0_if.req_ready, ram_en, ram_we, ram_wstrb); end
        total++; if (ram_addr !== 14'h40) begin bad++; $display("FAIL rd_addr got=%h exp=40", ram_addr); end
        @(negedge clk);
        drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        total++; if (m0_if.rsp_valid !== 1'b1 || m0_if.rsp_rdata !== 32'hDEADBEEF || m0_if.rsp_err !== 1'b0) begin bad++; $display("FAIL rd_rsp got=v%0b d%h e%0b exp=v1 deadbeef e0", m0_if.rsp_valid, m0_if.rsp_rdata, m0_if.rsp_err); end
        @(negedge clk); #1;
        total++; if (m0_if.rsp_valid !== 1'b0 || ram_en !== 1'b0) begin bad++; $display("FAIL idle got=v%0b en%0b exp=0 0", m0_if.rsp_valid, ram_en); end
    endtask

    task automatic test_contention;
        logic exp1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            drv0(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
            drv1(1'b1, 1'b0, 32'h200, 32'h0, 4'h0); #1;
            exp1 = (c % 9 == 0);
            total++; if (m1_if.req_ready !== exp1 || m0_if.req_ready !== !exp1) begin bad++; $display("FAIL contend_c%0d got=m0:%0b m1:%0b exp=m0:%0b m1:%0b", c, m0_if.req_ready, m1_if.req_ready, !exp1, exp1); end
        end
        @(negedge clk);
        drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); #1;
        total++; if ({m0_if.rsp_valid, m1_if.rsp_valid} !== 2'b00) begin bad++; $display("FAIL contend_drain got=%b exp=00", {m0_if.rsp_valid, m1_if.rsp_valid}); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        drv1(1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF); #1;
        total++; if (m1_if.req_ready !== 1'b1) begin bad++; $display("FAIL bp_wr_grant got=%0b exp=1", m1_if.req_ready); end
        @(negedge clk);
        drv1(1'b1, 1'b0, 32'h10, 32'h0, 4'h0); #1;
        total++; if (m1_if.req_ready !== 1'b1) begin bad++; $display("FAIL bp_rd_grant got=%0b exp=1", m1_if.req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            m1_if.rsp_ready = 1'b0;
            drv0(1'b1, 1'b0, 32'h200, 32'h0, 4'h0); #1;
            total++; if (m1_if.rsp_valid !== 1'b1 || m1_if.rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL bp_hold_c%0d got=v%0b d%h exp=v1 12345678", c, m1_if.rsp_valid, m1_if.rsp_rdata); end
            total++; if (m1_if.req_ready !== 1'b0 || m0_if.req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_c%0d got=m0:%0b m1:%0b exp=m0:1 m1:0", c, m0_if.req_ready, m1_if.req_ready); end
        end
        @(negedge clk);
        m1_if.rsp_ready = 1'b1;
        drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        total++; if (m1_if.rsp_valid !== 1'b1 || m1_if.rsp_rdata !== 32'h12345678 || m1_if.req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=v%0b d%h rdy%0b exp=v1 12345678 rdy1", m1_if.rsp_valid, m1_if.rsp_rdata, m1_if.req_ready); end
        @(negedge clk);
        drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        total++; if (m1_if.rsp_valid !== 1'b1 || m1_if.rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL bp_second got=v%0b d%h exp=v1 12345678", m1_if.rsp_valid, m1_if.rsp_rdata); end
        @(negedge clk); #1;
        total++; if ({m0_if.rsp_valid, m1_if.rsp_valid} !== 2'b00) begin bad++; $display("FAIL bp_drain got=%b exp=00", {m0_if.rsp_valid, m1_if.rsp_valid}); end
    endtask

    task automatic test_out_of_range;
        @(negedge clk);
        drv0(1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0); #1;
        total++; if (m0_if.req_ready !== 1'b1 || ram_en !== 1'b0) begin bad++; $display("FAIL oor_issue got=rdy%0b en%0b exp=rdy1 en0", m0_if.req_ready, ram_en); end
        @(negedge clk);
        drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        total++; if (m0_if.rsp_valid !== 1'b1 || m0_if.rsp_err !== 1'b1 || m0_if.rsp_rdata !== 32'h0) begin bad++; $display("FAIL oor_rsp got=v%0b e%0b d%h exp=v1 e1 d0", m0_if.rsp_valid, m0_if.rsp_err, m0_if.rsp_rdata); end
        @(negedge clk); #1;
    endtask

    task automatic test_partial_strobe;
        @(negedge clk);
        drv0(1'b1, 1'b1, 32'h300, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        drv0(1'b1, 1'b1, 32'h300, 32'h000000AA, 4'h1); #1;
        total++; if (ram_wstrb !== 4'h1) begin bad++; $display("FAIL strb_issue got=%h exp=1", ram_wstrb); end
        @(negedge clk);
        drv0(1'b1, 1'b0, 32'h302, 32'h0, 4'hF);
        @(negedge clk);
        drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        total++; if (m0_if.rsp_valid !== 1'b1 || m0_if.rsp_rdata !== 32'hFFFFFFAA) begin bad++; $display("FAIL strb_rd got=v%0b d%h exp=v1 ffffffaa", m0_if.rsp_valid, m0_if.rsp_rdata); end
        @(negedge clk); #1;
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        m0_if.rsp_ready = 1'b0;
        drv0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        drv1(1'b1, 1'b0, 32'h10, 32'h0, 4'h0); #1;
        total++; if (m0_if.req_ready !== 1'b1) begin bad++; $display("FAIL mid_grant got=%0b exp=1", m0_if.req_ready); end
        @(negedge clk);
        rst = 1'b1;
        drv0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); #1;
        total++; if ({m0_if.rsp_valid, m1_if.rsp_valid} !== 2'b00) begin bad++; $display("FAIL mid_rst_valid got=%b exp=00", {m0_if.rsp_valid, m1_if.rsp_valid}); end
        total++; if (dut.starve_cnt !== '0) begin bad++; $display("FAIL mid_rst_starve got=%0d exp=0", dut.starve_cnt); end
        @(negedge clk);
        rst = 1'b0;
        drv1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) m0_if.rsp_ready = 1'b1;
            #1;
            total++; if ({m0_if.rsp_valid, m1_if.rsp_valid} !== 2'b00) begin bad++; $display("FAIL mid_stale_c%0d got=%b exp=00", c, {m0_if.rsp_valid, m1_if.rsp_valid}); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_backpressure;
        test_out_of_range;
        test_partial_strobe;
        test_reset_midflight;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tcm_arbiter.md
Name: tcm_arbiter

Overview:
- Two-requester arbiter sharing one single-port, word-wide data TCM SRAM between the core load/store unit (m0) and a loader/debug master (m1).
- Sits between the LSU/peripheral bridge and the DTCM ram instance; the loader port lets program images be written at run time instead of by backdoor.
- Fixed priority to m0, with a starvation guard for m1.
- Per-master valid/ready request and response channels, 1-cycle SRAM read latency, one-entry response hold per master.

Parameters:
- ADDR_WIDTH, 16, byte-address width of the TCM window (the TCM holds 2^(ADDR_WIDTH-2) words).
- DATA_WIDTH, 32, word width; strobe width is DATA_WIDTH/8.
- STARVE_LIMIT, 8, number of consecutive cycles m1 may be valid-but-ungranted before it takes priority.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mN_req_valid  in  1  request valid (N = 0, 1).
- mN_req_ready  out  1  request accepted this cycle (valid && ready = grant).
- mN_req_we  in  1  1 = write, 0 = read.
- mN_req_addr  in  32  byte address; bits [1:0] are ignored.
- mN_req_wdata  in  DATA_WIDTH  write data.
- mN_req_wstrb  in  DATA_WIDTH/8  byte enables for writes.
- mN_rsp_valid  out  1  response valid; one response per granted request, reads and writes alike.
- mN_rsp_ready  in  1  master accepts the response.
- mN_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- mN_rsp_err  out  1  address was outside the TCM window.
- ram_en  out  1  SRAM access strobe.
- ram_we  out  1  SRAM write.
- ram_addr  out  ADDR_WIDTH-2  word index.
- ram_wdata  out  DATA_WIDTH  SRAM write data.
- ram_wstrb  out  DATA_WIDTH/8  SRAM byte enables.
- ram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after ram_en with ram_we=0.

Behaviour:
- Everything is synchronous to clk. Under rst, the following are 0:
  - all mN_req_ready, mN_rsp_valid, mN_rsp_err, mN_rsp_rdata;
  - ram_en, ram_we;
  - starvation counter;
  - priority-override flag;
  - in-flight tags;
  - hold buffers.
- Reset asserted mid-transaction drops every in-flight and held response; no response is emitted after reset releases.
- Eligibility: master N is eligible in cycle T iff both hold:
  - its hold slot is empty, or its held response is accepted in T (rsp_valid && rsp_ready);
  - no access issued for N in T-1 is still unaccepted at T.
- Grant selection:
  - m1 wins if the override flag is set, or if m0 is not valid/eligible.
  - Otherwise m0 wins.
  - At most one grant per cycle.
  - req_ready is combinational from valid and eligibility.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle m1 is valid and eligible but ungranted.
  - Clears on an m1 grant or when m1_req_valid is low.
  - When it reaches STARVE_LIMIT, the override flag sets; the flag clears on the next m1 grant.
- Range check: a request is out of range iff addr[31:ADDR_WIDTH] != 0.
  - Out-of-range grants do not drive ram_en.
  - Their response carries err=1, rdata=0, with the same 1-cycle latency.
- Issue: on an in-range grant in cycle T, the arbiter drives in T: ram_en=1, ram_we=req_we, ram_addr=addr[ADDR_WIDTH-1:2], ram_wdata, and ram_wstrb (forced to 0 for reads).
- Response timing:
  - In T+1 the granted master sees rsp_valid=1; rdata is ram_rdata for a read, 0 for a write.
  - If rsp_ready=0 in T+1, the response (data + err) is captured into that master's hold register and presented from it until accepted.
  - The response holds stable while valid and not ready.
- Back-to-back throughput:
  - With rsp_ready held high, a single master may be granted every cycle (1 access/cycle, latency 1).
  - Alternating masters also sustain 1 access/cycle.
- Ordering: responses are in-order per master; there is no cross-master ordering.
- Write followed by read of the same address is handled naturally by the SRAM. The arbiter adds no forwarding; the SRAM is required to be read-after-write coherent across cycles.

Decomposition:
- Shared package tcm_arb_pkg holds:
  - the typedef tcm_req_t {we, addr, wdata, wstrb};
  - the typedef tcm_rsp_t {rdata, err};
  - the master-index constants M_LSU=0 and M_LDR=1.
- One natural sub-module, tcm_rsp_slot: a per-master response hold (in-flight tag, hold register, valid/ready). It is instantiated twice.

Test Plan:
1. Single-master read/write: m0 writes 0xDEADBEEF to 0x100 with wstrb=0xF, then reads 0x100. Required: write rsp at T+1 with err=0; read rsp rdata=0xDEADBEEF at T+1; ram_addr=0x40.
2. Contention: m0 and m1 both valid every cycle with STARVE_LIMIT=8, rsp_ready=1. Required: m1 is granted exactly on cycle 9, then m0 for the next 8 cycles, repeating.
3. Backpressure: m1 reads 0x10 while m1_rsp_ready=0 for 5 cycles. Required: rsp_valid stays high, rdata stays stable, m1_req_ready=0 throughout; m0 keeps being granted; the next m1 grant comes in the cycle rsp_ready=1.
4. Out of range: m0 reads 0x0001_0000 with ADDR_WIDTH=16. Required: ram_en stays 0; rsp at T+1 with err=1, rdata=0.
5. Partial strobe: write 0xFFFFFFFF, then write 0x000000AA with wstrb=0x1, then read. Required: rdata=0xFFFFFFAA.
6. Reset mid-flight: assert rst in the cycle after a read grant with rsp_ready=0. Required: all rsp_valid are 0 after reset and no stale response appears later; the starvation counter is 0.
